// File: rtl/image_ram_writer.sv
// Write-side sequencer for the dual-port image RAM: streams one frame of DEPTH pixels into addresses 0..DEPTH-1.
// Optional IMG_WR_CHECKSUM_EN adds a running modulo-2**DATA_W checksum output of the accepted pixels.
module image_ram_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              we,
  output logic              busy,
  output logic              done
`ifdef IMG_WR_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              last;

  assign accept = s_valid & s_ready;
  assign last   = accept && (cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = WRITE;
      end
      WRITE: begin
        s_ready = 1'b1;
        if (last) state_nxt = DONE;
      end
      // final pixel's write lands in this cycle, so done lines up with the last we
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we        <= 1'b0;
      wraddress <= '0;
      data      <= '0;
      cnt       <= '0;
    end else begin
      we <= accept;
      if (accept) begin
        wraddress <= cnt;
        data      <= s_data;
        cnt       <= last ? '0 : cnt + 1'b1;
      end
    end
  end

`ifdef IMG_WR_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (accept)                 checksum <= checksum + s_data;
  end
`endif

endmodule

// File: tb/tb_image_ram_writer.sv
// Randomized scoreboard bench for image_ram_writer: a frame-level model predicts every RAM write,
// a negedge monitor pops and compares whenever we is high and mirrors the writes into a RAM array.
module tb_image_ram_writer;
  localparam int DW = 8, AW = 4, DEPTH = 16;

  logic          clock = 1'b0, reset_n = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, we, busy, done;
  logic [AW-1:0] wraddress;
  logic [DW-1:0] data;
`ifdef IMG_WR_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  image_ram_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wraddress(wraddress), .data(data), .we(we), .busy(busy), .done(done)
`ifdef IMG_WR_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] dat; logic last;} wr_t;
  typedef enum {M_IDLE, M_ACT, M_DONE} mode_t;

  wr_t           sb[$];
  wr_t           e;
  int            n_cmp = 0, n_err = 0;
  mode_t         mode = M_IDLE;
  int            idx = 0;
  logic [DW-1:0] csum = '0;
  logic [DW-1:0] ram [DEPTH];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every write must match the oldest predicted write
  always @(negedge clock) begin
    if (reset_n) begin
      if (we === 1'b1) begin
        if (sb.size() == 0) chk("unexpected_write", we, 0);
        else begin
          e = sb.pop_front();
          chk("wraddress", wraddress, e.addr);
          chk("data", data, e.dat);
          chk("done_with_we", done, e.last);
          ram[wraddress] = data;
        end
      end else chk("done_without_we", done, 0);
    end
  end

  // one clock of stimulus; entered and left at posedge+1
  task automatic cyc(logic st, logic v, logic [DW-1:0] d);
    start = st; s_valid = v; s_data = d;
    @(negedge clock);
    chk("s_ready", s_ready, mode == M_ACT);
    chk("busy", busy, mode != M_IDLE);
`ifdef IMG_WR_CHECKSUM_EN
    chk("checksum", checksum, csum);
`endif
    case (mode)
      M_IDLE: if (st) begin mode = M_ACT; idx = 0; csum = '0; end
      M_ACT: if (v) begin
        sb.push_back('{addr: idx[AW-1:0], dat: d, last: idx == DEPTH-1});
        csum = csum + d;
        idx++;
        if (idx == DEPTH) begin mode = M_DONE; idx = 0; end
      end
      default: mode = M_IDLE;
    endcase
    @(posedge clock); #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_wraddress"}, wraddress, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef IMG_WR_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  task automatic do_reset();
    start = 1'b1; s_valid = 1'b1; s_data = DW'($urandom);
    #1 reset_n = 1'b0;
    #1 chk_zero("reset");
    sb.delete(); mode = M_IDLE; idx = 0; csum = '0;
    @(posedge clock); @(posedge clock); #1;
    start = 1'b0; s_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  // vmode: 0 always valid, 1 pattern 1,0,0, 2 random; dmode: 0 random, 1 ramp 0x10+i, 2 all 0xFF
  task automatic frame(int vmode, int dmode, bit noisy_start);
    int c;
    logic v;
    logic [DW-1:0] d;
    cyc(1'b1, 1'(noisy_start ? $urandom_range(0, 1) : 0), DW'($urandom));
    c = 0;
    while (mode != M_IDLE && c < 300) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      d = (dmode == 1) ? DW'(8'h10 + idx) : (dmode == 2) ? DW'(8'hFF) : DW'($urandom);
      cyc(noisy_start ? 1'($urandom_range(0, 1)) : 1'b0, v, d);
      c++;
    end
    if (mode != M_IDLE) begin
      n_cmp++; n_err++;
      $display("FAIL frame_timeout: frame still open after %0d cycles", c);
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 chk_zero("por");
    reset_n = 1'b1;
    cyc(1'b0, 1'b1, 8'hAA);                  // valid in IDLE is ignored
    frame(0, 1, 1'b0);
    for (int i = 0; i < DEPTH; i++) chk("ram_ramp", ram[i], 8'h10 + i);
    frame(1, 0, 1'b0);
    frame(2, 0, 1'b1);                       // start noise mid-WRITE and in DONE
    cyc(1'b1, 1'b0, 8'h00);                  // abort: 7 pixels then reset
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, DW'($urandom));
    do_reset();
    for (int i = 0; i < DEPTH; i++) ram[i] = 'x;
    frame(0, 1, 1'b0);
    for (int i = 0; i < DEPTH; i++) chk("ram_after_abort", ram[i], 8'h10 + i);
    frame(0, 2, 1'b0);
`ifdef IMG_WR_CHECKSUM_EN
    chk("checksum_ff", checksum, 8'hF0);
`endif
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);                  // checksum cleared by the start
    for (int f = 0; f < 4; f++) frame(2, 0, f[0]);
    repeat (3) cyc(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
